instr_prefetch_queue: RTL and testbench
=======================================

# instr_prefetch_queue

Instruction prefetch stage placed directly upstream of the ALU core's decode flops. It drives the instruction ROM address, buffers fetched 28-bit instruction words with their addresses in a small circular queue, and hands them to the core over a valid/ready handshake. A taken branch or jump from the core flushes the queue and redirects fetch to the branch target.

## Interface
- `DEPTH`, default 4: queue entries; must be a power of two, 2..16.
- `ADDR_W`, default 16: instruction address width.
- `INSTR_W`, default 28: instruction word width.
- `Clock`  in  1  sole clock; all state updates on posedge.
- `Reset`  in  1  asynchronous, active-high reset.
- `oRomAddress`  out  ADDR_W  fetch address to the combinational ROM; equals the fetch PC register.
- `iRomInstruction`  in  INSTR_W  ROM data for `oRomAddress`, valid in the same cycle.
- `oInstruction`  out  INSTR_W  head-of-queue instruction.
- `oInstrAddress`  out  ADDR_W  address of `oInstruction`.
- `oValid`  out  1  head entry is valid.
- `iReady`  in  1  core accepts the head; a pop occurs when `oValid & iReady`.
- `iBranchTaken`  in  1  flush request from the core.
- `iBranchTarget`  in  ADDR_W  new fetch address, sampled when `iBranchTaken` = 1.
- `oCount`  out  $clog2(DEPTH)+1  current occupancy.
- `oFull`, `oEmpty`  out  1 each  `oCount == DEPTH` and `oCount == 0`.

## Operation
- State: fetch PC, read pointer, write pointer, count, and a storage array of `{address, instruction}` pairs.
- Reset values: fetch PC = 0, pointers = 0, count = 0. Outputs: `oValid` = 0, `oEmpty` = 1, `oFull` = 0, `oCount` = 0, `oRomAddress` = 0. `oInstruction` and `oInstrAddress` are 0 when empty.
- Pop condition: `oValid & iReady & ~iBranchTaken`.
- Fetch condition: `~iBranchTaken & (count < DEPTH | pop)`. A full queue that is popped in the same cycle still fetches.
- On a fetch edge: storage[wr] <= {PC, iRomInstruction}, wr <= wr+1, PC <= PC+1.
- On a pop edge: rd <= rd+1.
- count <= count + fetch − pop.
- Pointers wrap modulo DEPTH. PC wraps from all-ones to 0.
- Flush (`iBranchTaken` = 1) takes priority over everything else. On that edge: rd = wr = count = 0, PC <= iBranchTarget, no write and no pop. Queued entries are discarded.
- Flush while empty or full behaves the same: the queue is empty after the edge.
- An asserted `Reset` in mid-operation clears all state immediately, without waiting for a clock edge.
- Head outputs are driven from storage[rd] and are stable while `oValid` = 1 and `iReady` = 0.

## Timing
- Fetch throughput: one word per cycle while not full.
- Without bypass, latency from fetch to `oValid` is 1 cycle: a word fetched at edge N is visible after edge N.
- After a flush edge N, the target is fetched at edge N+1 and `oValid` = 1 after edge N+1.
- After the first edge following reset release, `oValid` = 1 with address 0.
- Sustained pop every cycle yields one instruction per cycle with no bubbles.

## Configuration
- Macro: `PREFETCH_BYPASS_EN`.
- Defined:
  - When the queue is empty and no flush is pending, the head outputs forward `{oRomAddress, iRomInstruction}` combinationally and `oValid` = 1.
  - If `iReady` = 1 in that cycle, the word is consumed: PC increments, nothing is written, and count stays 0.
  - Post-flush latency becomes 0: the target instruction is presented in the cycle after the flush edge.
- Undefined: there is no forwarding path. `oValid` = (count != 0), and the latencies in Timing apply.

## Test plan
- Reset with `iReady` = 0 for 6 cycles: after 4 fetches the queue holds addresses 0..3, `oFull` = 1, `oCount` = 4, and `oRomAddress` holds at 4.
- Full queue with `iReady` held at 1: addresses 0,1,2,... are delivered one per cycle, `oCount` stays 4, and the queue never drains.
- Flush with `iBranchTarget` = 16'h0020 while the queue holds 3 entries: `oValid` = 0 for 1 cycle (0 with bypass), then address 16'h0020 is followed by 16'h0021.
- Same-edge pop, fetch and flush: the flush wins, nothing is popped, count = 0, and the next fetch is from the target.
- PC wrap: flush to 16'hFFFE, giving delivered addresses FFFE, FFFF, 0000, 0001.
- Assert `Reset` asynchronously mid-cycle with 2 entries queued: `oValid` and `oCount` go to 0 immediately; after release, fetch restarts at address 0.

Source files
------------

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: drives ROM address, buffers {addr, instr} words, hands them to the core; optional PREFETCH_BYPASS_EN forwards ROM data when empty.
// Latency: fetch-to-oValid 1 cycle (0 with PREFETCH_BYPASS_EN); a taken branch flushes the queue and redirects fetch on the same edge.
// Backpressure: iReady low holds the head stable; fetch stalls only when full and not popped in the same cycle.
module instr_prefetch_queue #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 28
) (
    input  logic                       Clock,
    input  logic                       Reset,
    output logic [ADDR_W-1:0]          oRomAddress,
    input  logic [INSTR_W-1:0]         iRomInstruction,
    output logic [INSTR_W-1:0]         oInstruction,
    output logic [ADDR_W-1:0]          oInstrAddress,
    output logic                       oValid,
    input  logic                       iReady,
    input  logic                       iBranchTaken,
    input  logic [ADDR_W-1:0]          iBranchTarget,
    output logic [$clog2(DEPTH):0]     oCount,
    output logic                       oFull,
    output logic                       oEmpty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    entry_t            mem_q [DEPTH];

    entry_t head;
    logic   empty;
    logic   full;
    logic   q_pop;
    logic   byp_vld;
    logic   byp_take;
    logic   fetch;
    logic   wr_en;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign head  = mem_q[rd_ptr_q];

`ifdef PREFETCH_BYPASS_EN
    // Forwarding is suppressed during reset so outputs read as idle until release.
    assign byp_vld  = empty & ~iBranchTaken & ~Reset;
    assign byp_take = byp_vld & iReady;
`else
    assign byp_vld  = 1'b0;
    assign byp_take = 1'b0;
`endif

    assign q_pop = ~empty & iReady & ~iBranchTaken;
    assign fetch = ~iBranchTaken & (~full | q_pop);
    // A forwarded word is consumed straight from the ROM and never enters storage.
    assign wr_en = fetch & ~byp_take;

    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (iBranchTaken) begin
            pc_d     = iBranchTarget;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (fetch) pc_d = pc_q + 1'b1;
            if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (q_pop) rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(wr_en) - CNT_W'(q_pop);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pc_q     <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= '{addr: pc_q, instr: iRomInstruction};
        end
    end

    always_comb begin
        oValid        = ~empty | byp_vld;
        oInstruction  = '0;
        oInstrAddress = '0;
        if (byp_vld) begin
            oInstruction  = iRomInstruction;
            oInstrAddress = pc_q;
        end else if (~empty) begin
            oInstruction  = head.instr;
            oInstrAddress = head.addr;
        end
    end

    assign oRomAddress = pc_q;
    assign oCount      = count_q;
    assign oFull       = full;
    assign oEmpty      = empty;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue with a scoreboard of expected delivered addresses.
module tb_instr_prefetch_queue;

    logic        Clock;
    logic        Reset;
    logic [15:0] oRomAddress;
    logic [27:0] iRomInstruction;
    logic [27:0] oInstruction;
    logic [15:0] oInstrAddress;
    logic        oValid;
    logic        iReady;
    logic        iBranchTaken;
    logic [15:0] iBranchTarget;
    logic [2:0]  oCount;
    logic        oFull;
    logic        oEmpty;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];

    instr_prefetch_queue #(.DEPTH(4), .ADDR_W(16), .INSTR_W(28)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .oRomAddress(oRomAddress),
        .iRomInstruction(iRomInstruction),
        .oInstruction(oInstruction),
        .oInstrAddress(oInstrAddress),
        .oValid(oValid),
        .iReady(iReady),
        .iBranchTaken(iBranchTaken),
        .iBranchTarget(iBranchTarget),
        .oCount(oCount),
        .oFull(oFull),
        .oEmpty(oEmpty)
    );

    function automatic logic [27:0] rom_f(input logic [15:0] a);
        return {4'h9, a ^ 16'h5A5A, a[7:0] + 8'h33};
    endfunction

    always_comb iRomInstruction = rom_f(oRomAddress);

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic flush_to(input logic [15:0] tgt);
        iBranchTaken  = 1'b1;
        iBranchTarget = tgt;
        step();
        iBranchTaken  = 1'b0;
    endtask

    // Monitor: every accepted head must match the next expected address and its ROM word.
    always @(negedge Clock) begin
        if (!Reset && oValid && iReady && !iBranchTaken) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_delivery: got addr %0h expected none", oInstrAddress);
            end else begin
                logic [15:0] ea;
                ea = exp_q.pop_front();
                chk("deliv_addr", 32'(oInstrAddress), 32'(ea));
                chk("deliv_instr", 32'(oInstruction), 32'(rom_f(ea)));
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset         = 1'b1;
        iReady        = 1'b0;
        iBranchTaken  = 1'b0;
        iBranchTarget = 16'h0000;
        #12;
        chk("rst_valid", 32'(oValid), 0);
        chk("rst_empty", 32'(oEmpty), 1);
        chk("rst_full", 32'(oFull), 0);
        chk("rst_count", 32'(oCount), 0);
        chk("rst_romaddr", 32'(oRomAddress), 0);
        chk("rst_instr", 32'(oInstruction), 0);
        chk("rst_iaddr", 32'(oInstrAddress), 0);

        @(negedge Clock);
        Reset = 1'b0;
        step();
        chk("first_valid", 32'(oValid), 1);
        chk("first_iaddr", 32'(oInstrAddress), 0);
        chk("first_count", 32'(oCount), 1);
        repeat (5) step();
        chk("fill_full", 32'(oFull), 1);
        chk("fill_count", 32'(oCount), 4);
        chk("fill_romaddr", 32'(oRomAddress), 4);
        chk("fill_head", 32'(oInstrAddress), 0);

        // Sustained pop on a full queue: one word per cycle, occupancy holds at 4.
        for (int i = 0; i < 6; i++) exp_q.push_back(16'(i));
        iReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("stream_count", 32'(oCount), 4);
        end
        iReady = 1'b0;
        chk("stream_head", 32'(oInstrAddress), 6);

        flush_to(16'h0100);
        chk("fl1_count", 32'(oCount), 0);
        repeat (3) step();
        chk("three_count", 32'(oCount), 3);
        chk("three_head", 32'(oInstrAddress), 16'h0100);

        // Flush with pop and fetch also requested on the same edge.
        iReady = 1'b1;
        flush_to(16'h0020);
        iReady = 1'b0;
        chk("fl2_count", 32'(oCount), 0);
        chk("fl2_romaddr", 32'(oRomAddress), 16'h0020);
`ifdef PREFETCH_BYPASS_EN
        chk("fl2_valid", 32'(oValid), 1);
        chk("fl2_iaddr", 32'(oInstrAddress), 16'h0020);
`else
        chk("fl2_valid", 32'(oValid), 0);
`endif
        step();
        chk("fl2_valid_next", 32'(oValid), 1);
        exp_q.push_back(16'h0020);
        exp_q.push_back(16'h0021);
        iReady = 1'b1;
        repeat (2) step();
        iReady = 1'b0;
        chk("fl2_count_after", 32'(oCount), 1);
        chk("fl2_head_after", 32'(oInstrAddress), 16'h0022);

        flush_to(16'hFFFE);
        step();
        exp_q.push_back(16'hFFFE);
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0001);
        iReady = 1'b1;
        repeat (4) step();
        iReady = 1'b0;
        chk("wrap_head", 32'(oInstrAddress), 16'h0002);
        chk("wrap_count", 32'(oCount), 1);

        flush_to(16'h0040);
        repeat (2) step();
        chk("pre_arst_count", 32'(oCount), 2);
        #2;
        Reset = 1'b1;
        #1;
        chk("arst_valid", 32'(oValid), 0);
        chk("arst_count", 32'(oCount), 0);
        chk("arst_romaddr", 32'(oRomAddress), 0);
        #4;
        Reset = 1'b0;
        step();
        chk("restart_valid", 32'(oValid), 1);
        chk("restart_iaddr", 32'(oInstrAddress), 0);
        chk("restart_romaddr", 32'(oRomAddress), 1);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0001);
        iReady = 1'b1;
        repeat (2) step();
        iReady = 1'b0;
        repeat (2) step();
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
